// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state and result encodings for the serial comparator
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Result vectors are ordered {LG, EQ, RG}
  localparam logic [2:0] RES_LG   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_RG   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_comp.sv
// rtl/digit_comp.sv - combinational one-hot magnitude compare of one digit
module digit_comp
  import comp_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  output logic [2:0]       RES
);

  always_comb begin
    RES = RES_EQ;
    if (A > B)      RES = RES_LG;
    else if (A < B) RES = RES_RG;
  end

endmodule

// File: rtl/serial_comp.sv
// rtl/serial_comp.sv - digit-serial signed/unsigned comparator with early exit
module serial_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             SIGNED_MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             LG_OUT,
  output logic             EQ_OUT,
  output logic             RG_OUT
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic [2:0]       res_q;

  logic [DIGIT-1:0] sign_flip;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [2:0]       dig_res;

  // Flipping both sign bits maps two's-complement order onto unsigned order
  always_comb begin
    sign_flip = '0;
    if (sgn_q && idx == TOP_IDX) sign_flip[DIGIT-1] = 1'b1;
    a_dig = DIGIT'(x_q >> (int'(idx) * DIGIT)) ^ sign_flip;
    b_dig = DIGIT'(y_q >> (int'(idx) * DIGIT)) ^ sign_flip;
  end

  digit_comp #(.DIGIT(DIGIT)) u_digit (
    .A   (a_dig),
    .B   (b_dig),
    .RES (dig_res)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      res_q     <= RES_NONE;
      idx       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sgn_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            x_q      <= X;
            y_q      <= Y;
            sgn_q    <= SIGNED_MODE;
            idx      <= TOP_IDX;
            IN_READY <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (dig_res != RES_EQ || idx == '0) begin
            res_q     <= dig_res;
            OUT_VALID <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            res_q     <= RES_NONE;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          res_q     <= RES_NONE;
          OUT_VALID <= 1'b0;
          IN_READY  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign {LG_OUT, EQ_OUT, RG_OUT} = res_q;

endmodule

// File: tb/tb_serial_comp.sv
// tb/tb_serial_comp.sv - scoreboard bench for serial_comp
module tb_serial_comp;
  import comp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid0, in_ready0, sm0, out_valid0, out_ready0, lg0, eq0, rg0;
  logic [15:0] x0, y0;
  logic        in_valid1, in_ready1, sm1, out_valid1, out_ready1, lg1, eq1, rg1;
  logic [7:0]  x1, y1;

  serial_comp #(.WIDTH(16), .DIGIT(4)) dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid0), .IN_READY(in_ready0),
    .X(x0), .Y(y0), .SIGNED_MODE(sm0), .OUT_VALID(out_valid0),
    .OUT_READY(out_ready0), .LG_OUT(lg0), .EQ_OUT(eq0), .RG_OUT(rg0)
  );

  serial_comp #(.WIDTH(8), .DIGIT(8)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .X(x1), .Y(y1), .SIGNED_MODE(sm1), .OUT_VALID(out_valid1),
    .OUT_READY(out_ready1), .LG_OUT(lg1), .EQ_OUT(eq1), .RG_OUT(rg1)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  int   hs0[$];
  int   hs1[$];
  int   cyc = 0;
  int   last_hs1 = -1;
  int   checks = 0;
  int   fails = 0;
  logic ov0_prev = 1'b0;
  logic ov1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    int   h;
    if (rst) begin
      hs0.delete();
      ov0_prev <= 1'b0;
    end else begin
      if (in_valid0 && in_ready0) hs0.push_back(cyc);
      if (out_valid0 && !ov0_prev) begin
        if (exp0.size() == 0 || hs0.size() == 0) begin
          timeout("dut0 unexpected result");
        end else begin
          e = exp0.pop_front();
          h = hs0.pop_front();
          chk("dut0 result", {29'd0, lg0, eq0, rg0}, {29'd0, e.res});
          chk("dut0 latency", cyc - h, e.lat);
        end
      end
      if (!out_valid0) chk("dut0 flags idle", {29'd0, lg0, eq0, rg0}, 0);
      else             chk("dut0 onehot", 32'($onehot({lg0, eq0, rg0})), 1);
      ov0_prev <= out_valid0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    int   h;
    if (rst) begin
      hs1.delete();
      ov1_prev <= 1'b0;
    end else begin
      if (in_valid1 && in_ready1) begin
        hs1.push_back(cyc);
        if (last_hs1 >= 0) chk("dut1 accept interval", cyc - last_hs1, 3);
        last_hs1 <= cyc;
      end
      if (out_valid1 && !ov1_prev) begin
        if (exp1.size() == 0 || hs1.size() == 0) begin
          timeout("dut1 unexpected result");
        end else begin
          e = exp1.pop_front();
          h = hs1.pop_front();
          chk("dut1 result", {29'd0, lg1, eq1, rg1}, {29'd0, e.res});
          chk("dut1 latency", cyc - h, e.lat);
        end
      end
      ov1_prev <= out_valid1;
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge
  task automatic send0(input logic [15:0] xv, input logic [15:0] yv, input logic s,
                       input logic [2:0] r, input int lat, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    x0 = xv; y0 = yv; sm0 = s; in_valid0 = 1'b1;
    if (push) begin
      e.res = r; e.lat = lat;
      exp0.push_back(e);
    end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready0) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid0 = 1'b0;
    if (!ok) timeout("dut0 request accept");
  endtask

  task automatic send1(input logic [7:0] xv, input logic [7:0] yv, input logic s,
                       input logic [2:0] r);
    exp_t e;
    bit   ok = 1'b0;
    x1 = xv; y1 = yv; sm1 = s; in_valid1 = 1'b1;
    e.res = r; e.lat = 2;
    exp1.push_back(e);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid1 = 1'b0;
    if (!ok) timeout("dut1 request accept");
  endtask

  task automatic wait_idle0();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready0) ok = 1'b1;
    end
    if (!ok) timeout("dut0 return to idle");
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    in_valid0 = 1'b0; x0 = '0; y0 = '0; sm0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; x1 = '0; y1 = '0; sm1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready0", in_ready0, 1);
    chk("reset out_valid0", out_valid0, 0);
    chk("reset flags0", {29'd0, lg0, eq0, rg0}, 0);
    chk("reset in_ready1", in_ready1, 1);
    chk("reset out_valid1", out_valid1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send0(16'h1234, 16'h1234, 1'b0, RES_EQ, 5, 1'b1); wait_idle0();
    send0(16'h8000, 16'h7FFF, 1'b0, RES_LG, 2, 1'b1); wait_idle0();
    send0(16'h8000, 16'h7FFF, 1'b1, RES_RG, 2, 1'b1); wait_idle0();
    send0(16'h00A5, 16'h00A6, 1'b0, RES_RG, 5, 1'b1); wait_idle0();
    send0(16'hFFFF, 16'h0001, 1'b1, RES_RG, 2, 1'b1); wait_idle0();
    send0(16'h0001, 16'hFFFF, 1'b1, RES_LG, 2, 1'b1); wait_idle0();
    send0(16'hFFF0, 16'hFFF1, 1'b1, RES_RG, 5, 1'b1); wait_idle0();
    send0(16'h8000, 16'h8000, 1'b1, RES_EQ, 5, 1'b1); wait_idle0();
    send0(16'h0120, 16'h0100, 1'b0, RES_LG, 4, 1'b1); wait_idle0();

    // Back-pressure in HOLD while the request side keeps wiggling
    out_ready0 = 1'b0;
    send0(16'h1234, 16'h1233, 1'b0, RES_LG, 5, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (out_valid0) ok = 1'b1;
    end
    if (!ok) timeout("dut0 hold entry");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid0 = 1'b1;
      x0 = ~x0;
      y0 = y0 ^ 16'h5A5A;
      @(negedge clk);
      chk("hold flags", {29'd0, lg0, eq0, rg0}, {29'd0, RES_LG});
      chk("hold out_valid", out_valid0, 1);
      chk("hold in_ready", in_ready0, 0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release in_ready", in_ready0, 1);
    chk("release out_valid", out_valid0, 0);
    @(posedge clk); #1;

    // Reset in the second SCAN cycle discards the operation
    send0(16'h1234, 16'h1234, 1'b0, RES_NONE, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready0, 1);
    for (int i = 0; i < 6; i++) begin
      chk("post-reset out_valid", out_valid0, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send0(16'h00A5, 16'h00A6, 1'b0, RES_RG, 5, 1'b1); wait_idle0();

    // Single-digit instance, back-to-back requests
    send1(8'h05, 8'h03, 1'b0, RES_LG);
    send1(8'h80, 8'h7F, 1'b1, RES_RG);
    send1(8'h80, 8'h7F, 1'b0, RES_LG);
    send1(8'h42, 8'h42, 1'b1, RES_EQ);
    send1(8'hFF, 8'h01, 1'b1, RES_RG);
    send1(8'h01, 8'hFF, 1'b0, RES_RG);

    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !out_valid1) ok = 1'b1;
    end
    chk("scoreboard drained", 32'(exp0.size() + exp1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_comp.md
SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (>= 2).
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits compared per cycle; WIDTH % DIGIT == 0; N = WIDTH/DIGIT.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port IN_VALID, input, 1, meaning the operand request is valid.
REQ-006 The block SHALL have port IN_READY, output, 1, meaning the block accepts an operand request.
REQ-007 The block SHALL have ports X and Y, input, WIDTH, the operands.
REQ-008 The block SHALL have port SIGNED_MODE, input, 1, selecting two's-complement comparison when 1; it is sampled with the operands.
REQ-009 The block SHALL have port OUT_VALID, output, 1, meaning the result is valid.
REQ-010 The block SHALL have port OUT_READY, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have ports LG_OUT, EQ_OUT and RG_OUT, output, 1 each, meaning the one-hot result X>Y, X==Y and X<Y respectively.

Function
REQ-012 Request handshake SHALL occur when IN_VALID&&IN_READY; X, Y and SIGNED_MODE SHALL be registered in that cycle.
REQ-013 FSM states SHALL be IDLE, SCAN and HOLD.
REQ-014 IDLE: IN_READY=1, OUT_VALID=0; on request handshake the FSM SHALL go to SCAN with digit index = N-1 (MSB digit).
REQ-015 SCAN: each cycle SHALL compare one DIGIT-bit slice of the captured operands, MSB digit first.
REQ-016 Unsigned mode SHALL perform a plain magnitude compare of each digit.
REQ-017 Signed mode SHALL invert the operand sign bits in digit N-1 only; all lower digits compare unsigned.
REQ-018 If the current digit differs, SCAN SHALL latch LG or RG and go to HOLD (early termination).
REQ-019 If the digits are equal and the index is 0, SCAN SHALL latch EQ and go to HOLD; otherwise it SHALL decrement the index and stay in SCAN.
REQ-020 Latency: if k is the number of digits scanned (1..N), OUT_VALID SHALL rise exactly k+1 cycles after the request handshake cycle.
REQ-021 HOLD: OUT_VALID=1, exactly one of LG_OUT/EQ_OUT/RG_OUT = 1, and all outputs SHALL stay stable until OUT_VALID&&OUT_READY.
REQ-022 On the result handshake the FSM SHALL go to IDLE; the next request can therefore be accepted one cycle later.
REQ-023 When OUT_VALID=0, LG_OUT, EQ_OUT and RG_OUT SHALL all be 0.
REQ-024 IN_READY SHALL be 0 in SCAN and HOLD, and IN_VALID SHALL be ignored there; operand input changes after capture SHALL have no effect.
REQ-025 When N=1, SCAN SHALL always exit after one cycle (latency 2).

Reset
REQ-026 While RST=1 at a clock edge, the FSM SHALL go to IDLE; OUT_VALID, LG_OUT, EQ_OUT and RG_OUT SHALL be 0, IN_READY SHALL be 1 on the next cycle, and the digit index and operand registers SHALL be cleared.
REQ-027 RST SHALL take priority over any handshake in the same cycle, and a reset during SCAN or HOLD SHALL discard the operation without emitting a result.

Structure
REQ-028 Shared package comp_pkg SHALL hold the state encoding (IDLE/SCAN/HOLD) and the result encoding constants RES_LG=3'b100, RES_EQ=3'b010, RES_RG=3'b001 (order {LG,EQ,RG}).
REQ-029 One combinational sub-module, digit_comp (parameter DIGIT, inputs A and B, output 3-bit one-hot result), SHALL be instantiated once and driven by the index-selected slices.
REQ-030 The digit index register SHALL be $clog2(N) bits wide, with a minimum of 1.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 Unsigned X=16'h1234, Y=16'h1234 SHALL give EQ_OUT=1, with OUT_VALID 5 cycles after the handshake.
REQ-032 X=16'h8000, Y=16'h7FFF SHALL give, with unsigned mode, LG_OUT=1 at latency 2, and with signed mode, RG_OUT=1 at latency 2.
REQ-033 Unsigned X=16'h00A5, Y=16'h00A6 SHALL give RG_OUT=1 at latency 5.
REQ-034 With OUT_READY=0 for 3 cycles in HOLD while IN_VALID=1 and X/Y toggle, outputs SHALL be stable and IN_READY SHALL be 0; after OUT_READY=1, IDLE SHALL follow the next cycle.
REQ-035 RST pulsed in the second SCAN cycle SHALL cause no OUT_VALID pulse, IDLE on the next cycle, and a fresh request SHALL then complete correctly.
REQ-036 With WIDTH=8, DIGIT=8 and back-to-back requests with OUT_READY=1, every result SHALL have latency 2, and a new request SHALL be accepted every 3 cycles.
